// File: rtl/display_manager.sv
// display_manager
//   Converts a 12-bit binary result into four BCD digits with an iterative
//   shift-add-3 (double dabble) sequence. It then time-multiplexes those
//   digits onto a 4-digit common-anode 7-segment display.
//
//   State table:
//     state | meaning
//     IDLE  | waiting for number_valid; display shows last completed value
//     SHIFT | one add-3/shift step per clock, 12 steps total
//     DONE  | one-cycle completion pulse; bcd_out/display just updated
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   number_in    unsigned binary value to convert (0..4095)
//   number_valid request strobe, sampled only in IDLE
//   busy         conversion in progress (SHIFT or DONE)
//   done         one-cycle pulse when bcd_out and the display are updated
//   bcd_out      {thousands, hundreds, tens, units} BCD
//   an           active-low digit enables, an[0] = units
//   seg          active-low segments {g,f,e,d,c,b,a}
module display_manager #(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_ZEROS = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] number_in,
  input  logic        number_valid,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd_out,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nxt;
  logic [11:0] bin_sr;
  logic [15:0] bcd_sr;
  logic [3:0]  bit_cnt;
  logic [15:0] disp_reg;
  logic [15:0] bcd_adj;
  logic [15:0] bcd_shift;
  logic [CW-1:0] refresh_cnt;
  logic [1:0]  digit_sel;
  logic [3:0]  digit;
  logic        blank;

  // Add-3 correction on every nibble, then shift the binary MSB in.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < 4; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj[14:0], bin_sr[11]};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (number_valid) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == 4'd11) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_sr   <= '0;
      bcd_sr   <= '0;
      bit_cnt  <= '0;
      bcd_out  <= '0;
      disp_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (number_valid) begin
            bin_sr  <= number_in;
            bcd_sr  <= '0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          bcd_sr  <= bcd_shift;
          bin_sr  <= {bin_sr[10:0], 1'b0};
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd11) begin
            bcd_out  <= bcd_shift;
            disp_reg <= bcd_shift;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Refresh timing is free-running and independent of the conversion FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= '0;
      digit_sel   <= '0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      digit_sel   <= digit_sel + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  always_comb begin
    digit = disp_reg[3:0];
    blank = 1'b0;
    case (digit_sel)
      2'd0: digit = disp_reg[3:0];
      2'd1: begin
        digit = disp_reg[7:4];
        blank = BLANK_ZEROS && (disp_reg[15:4] == 12'd0);
      end
      2'd2: begin
        digit = disp_reg[11:8];
        blank = BLANK_ZEROS && (disp_reg[15:8] == 8'd0);
      end
      default: begin
        digit = disp_reg[15:12];
        blank = BLANK_ZEROS && (disp_reg[15:12] == 4'd0);
      end
    endcase
  end

  always_comb begin
    an  = ~(4'b0001 << digit_sel);
    seg = 7'b1111111;
    if (blank) begin
      an = 4'b1111;
    end else begin
      case (digit)
        4'd0: seg = 7'b1000000;
        4'd1: seg = 7'b1111001;
        4'd2: seg = 7'b0100100;
        4'd3: seg = 7'b0110000;
        4'd4: seg = 7'b0011001;
        4'd5: seg = 7'b0010010;
        4'd6: seg = 7'b0000010;
        4'd7: seg = 7'b1111000;
        4'd8: seg = 7'b0000000;
        4'd9: seg = 7'b0010000;
        default: seg = 7'b1111111;
      endcase
    end
  end

endmodule
